// File: rtl/mem_pkg.sv
// Shared definitions for the burst master, its memory and the bench.
//   MEM_ADDR_W / MEM_DATA_W / MEM_LEN_W : default geometry (32 x 8, 1..8 beats)
//   mem_state_e                         : burst master FSM state encoding
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned MEM_LEN_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_burst_master.sv
// Burst master: accepts one read or write burst command at a time and
// sequences it onto a single-port synchronous memory.
//   clk, rst_n                      : clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len : burst command handshake
//   wr_valid/wr_ready/wr_data       : write beats, consumed only in WRITE
//   rd_valid/rd_data                : read beats, no backpressure
//   done                            : one-cycle burst-complete pulse
//   mem_write/mem_read/mem_addr/mem_data_in/mem_data_out : memory side
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              done_q, done_d;
  logic              rd_pend_q, rd_pend_d;   // memory data returns next cycle
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      done_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      done_q     <= done_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Next-state and memory strobe logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    rd_pend_d   = 1'b0;
    rd_valid_d  = rd_pend_q;
    rd_data_d   = rd_pend_q ? mem_data_out : rd_data_q;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_data_in = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          beat_d  = '0;
          state_d = cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_write   = 1'b1;
          mem_data_in = wr_data;
          addr_d      = ADDR_W'(addr_q + 1'b1);
          beat_d      = LEN_W'(beat_q + 1'b1);
          if (beat_q == len_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        mem_read  = 1'b1;
        rd_pend_d = 1'b1;
        addr_d    = ADDR_W'(addr_q + 1'b1);
        beat_d    = LEN_W'(beat_q + 1'b1);
        if (beat_q == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Last read is in flight; done lands with its rd_valid.
        if (rd_pend_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr = addr_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master with a behavioural memory and
// scoreboard queues for memory writes, read addresses and read data.
module tb_mem_burst_master;
  import mem_pkg::*;

  localparam int unsigned AW = MEM_ADDR_W;
  localparam int unsigned DW = MEM_DATA_W;
  localparam int unsigned LW = MEM_LEN_W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  wr_exp_t       exp_wr_q[$];
  logic [AW-1:0] exp_rd_addr_q[$];
  logic [DW-1:0] exp_rdata_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  always #5 clk = ~clk;

  mem_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Synchronous memory: read data registered on the edge sampling mem_read
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read)  mem_data_out  <= mem[mem_addr];
  end

  // Per-cycle monitor: strobe exclusivity and scoreboard pops
  always @(negedge clk) begin
    if (mon_en) begin
      wr_exp_t e;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      vectors++;
      if ((mem_read & mem_write) !== 1'b0) begin
        miscompares++;
        $display("FAIL strobe_excl: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
      end
      if (mem_write === 1'b1) begin
        vectors++;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%0d data=%h, none required", mem_addr, mem_data_in);
        end else begin
          e = exp_wr_q.pop_front();
          if (mem_addr !== e.addr || mem_data_in !== e.data) begin
            miscompares++;
            $display("FAIL mem_write_beat: addr=%0d data=%h required addr=%0d data=%h",
                     mem_addr, mem_data_in, e.addr, e.data);
          end
        end
      end
      if (mem_read === 1'b1) begin
        vectors++;
        if (exp_rd_addr_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_read: addr=%0d, none required", mem_addr);
        end else begin
          a = exp_rd_addr_q.pop_front();
          if (mem_addr !== a) begin
            miscompares++;
            $display("FAIL mem_read_addr: addr=%0d required %0d", mem_addr, a);
          end
        end
      end
      if (rd_valid === 1'b1) begin
        vectors++;
        if (exp_rdata_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rd_valid: rd_data=%h, none required", rd_data);
        end else begin
          d = exp_rdata_q.pop_front();
          if (rd_data !== d) begin
            miscompares++;
            $display("FAIL rd_data: got %h required %h", rd_data, d);
          end
        end
      end
    end
  end

  // Issue a write burst; vpat gives wr_valid per cycle (1 beyond npat)
  task automatic write_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input logic [DW-1:0] base, input logic [15:0] vpat,
                             input int npat);
    int beats = 0;
    int cyc   = 0;
    logic v;
    logic [AW-1:0] a;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_cmd_ready: got %b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (beats <= int'(len) && cyc < 64) begin
      v = (cyc < npat) ? vpat[cyc] : 1'b1;
      wr_valid = v;
      wr_data  = DW'(base + beats);
      if (v) begin
        a = AW'(addr + beats);
        exp_wr_q.push_back('{addr: a, data: wr_data});
        ref_mem[a] = wr_data;
      end
      @(negedge clk);
      vectors++;
      if (wr_ready !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0 || mem_write !== v) begin
        miscompares++;
        $display("FAIL wr_beat_ctl: wr_ready=%b cmd_ready=%b done=%b mem_write=%b required 1 0 0 %b",
                 wr_ready, cmd_ready, done, mem_write, v);
      end
      @(posedge clk); #1;
      if (v) beats++;
      cyc++;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || wr_ready !== 1'b0 || mem_write !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_done: done=%b wr_ready=%b mem_write=%b cmd_ready=%b required 1 0 0 1",
               done, wr_ready, mem_write, cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  // Issue a read burst and check strobe/rd_valid/done timing per cycle
  task automatic read_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    logic exp_rd, exp_rv, exp_done;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_cmd_ready: got %b required 1", cmd_ready);
    end
    for (int b = 0; b <= int'(len); b++) begin
      a = AW'(addr + b);
      exp_rd_addr_q.push_back(a);
      exp_rdata_q.push_back(ref_mem[a]);
    end
    @(posedge clk); #1;
    for (int k = 0; k <= int'(len) + 3; k++) begin
      // Stray write beats and commands while busy must be ignored
      wr_valid  = (k <= int'(len));
      wr_data   = 8'hEE;
      cmd_valid = (k <= int'(len));
      cmd_addr  = 5'd17;
      exp_rd    = (k <= int'(len));
      exp_rv    = (k >= 2 && k <= int'(len) + 2);
      exp_done  = (k == int'(len) + 2);
      @(negedge clk);
      vectors++;
      if (mem_read !== exp_rd || rd_valid !== exp_rv || done !== exp_done ||
          mem_write !== 1'b0 || wr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_cycle%0d: mem_read=%b rd_valid=%b done=%b mem_write=%b wr_ready=%b required %b %b %b 0 0",
                 k, mem_read, rd_valid, done, mem_write, wr_ready, exp_rd, exp_rv, exp_done);
      end
      @(posedge clk); #1;
      if (k == int'(len) + 1) begin
        wr_valid = 1'b0;
        cmd_valid = 1'b0;
      end
    end
    wr_valid  = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    vectors++;
    if (done !== 1'b0 || rd_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        wr_ready !== 1'b0 || mem_addr !== '0 || rd_data !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: done=%b rd_valid=%b mem_read=%b mem_write=%b wr_ready=%b mem_addr=%0d rd_data=%h required all 0",
               done, rd_valid, mem_read, mem_write, wr_ready, mem_addr, rd_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst();
    write_burst(5'd4, 3'd3, 8'hA0, 16'hFFFF, 0);
  endtask

  task automatic test_read_burst();
    read_burst(5'd4, 3'd3);
  endtask

  task automatic test_wrap();
    write_burst(5'd30, 3'd3, 8'h11, 16'hFFFF, 0);
    read_burst(5'd30, 3'd3);
  endtask

  task automatic test_write_stall();
    // wr_valid pattern 1,0,0,1,1 carries exactly three beats
    write_burst(5'd10, 3'd2, 8'h50, 16'b11001, 5);
    read_burst(5'd10, 3'd2);
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd0; cmd_len = 3'd7;
    for (int b = 0; b < 8; b++) begin
      exp_rd_addr_q.push_back(AW'(b));
      exp_rdata_q.push_back(ref_mem[b]);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 5'd2) begin
      miscompares++;
      $display("FAIL pre_reset_beat2: mem_read=%b mem_addr=%0d required 1 2", mem_read, mem_addr);
    end
    @(posedge clk); #1;
    exp_rd_addr_q.delete();
    exp_rdata_q.delete();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (mem_read !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet%0d: mem_read=%b rd_valid=%b done=%b required 0 0 0",
                 k, mem_read, rd_valid, done);
      end
      @(posedge clk); #1;
    end
    // Release-then-command on the very next cycle
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_burst(5'd4, 3'd1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom_range(0, 2**AW - 1));
      l = LW'($urandom_range(0, 2**LW - 1));
      write_burst(a, l, DW'($urandom), 16'hFFFF, 0);
      read_burst(a, l);
    end
  endtask

  task automatic test_drain_queues();
    vectors++;
    if (exp_wr_q.size() != 0 || exp_rd_addr_q.size() != 0 || exp_rdata_q.size() != 0) begin
      miscompares++;
      $display("FAIL queues_empty: wr=%0d rd_addr=%0d rdata=%0d required 0 0 0",
               exp_wr_q.size(), exp_rd_addr_q.size(), exp_rdata_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_write_stall();
    test_reset_mid_read();
    test_back_to_back();
    repeat (3) @(posedge clk);
    test_drain_queues();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
MEM_BURST_MASTER -- requirements
Module: mem_burst_master

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width (32 locations).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter LEN_W, default 3, burst-length field width (bursts of 1..8 beats).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 cmd_valid  in  1  burst command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  ADDR_W  start address.
REQ-010 cmd_len  in  LEN_W  beats minus one.
REQ-011 wr_valid  in  1  write-data beat offered.
REQ-012 wr_ready  out  1  write beat consumed when wr_valid && wr_ready.
REQ-013 wr_data  in  DATA_W  write-data beat.
REQ-014 rd_valid  out  1  read-data beat valid for one cycle; no backpressure.
REQ-015 rd_data  out  DATA_W  read-data beat.
REQ-016 done  out  1  one-cycle pulse when a burst completes.
REQ-017 mem_write  out  1  memory write strobe.
REQ-018 mem_read  out  1  memory read strobe.
REQ-019 mem_addr  out  ADDR_W  memory address.
REQ-020 mem_data_in  out  DATA_W  data to memory.
REQ-021 mem_data_out  in  DATA_W  memory read data, registered by memory on the edge sampling mem_read.

Function
REQ-022 FSM states: IDLE, WRITE, READ, DRAIN.
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the IDLE edge where cmd_valid=1, and the start address and length are latched then.
REQ-024 Accepted command SHALL move IDLE->WRITE if cmd_write=1, else IDLE->READ.
REQ-025 In WRITE, wr_ready=1; each cycle with wr_valid=1 SHALL drive mem_write=1, mem_addr=current address, mem_data_in=wr_data combinationally; a cycle with wr_valid=0 drives mem_write=0 and does not advance.
REQ-026 In READ, mem_read=1 with mem_addr=current address on every cycle, one beat per cycle.
REQ-027 The address SHALL increment by 1 per issued beat, modulo 2**ADDR_W (31 wraps to 0).
REQ-028 A beat counter SHALL count issued beats; after beat cmd_len+1, WRITE->IDLE with done=1 on the following cycle, and READ->DRAIN.
REQ-029 Read data SHALL be captured into rd_data on the edge after mem_data_out updates; rd_valid is asserted exactly 2 cycles after the corresponding mem_read cycle, in issue order, one rd_valid per beat.
REQ-030 DRAIN SHALL hold mem_read=0 until the last rd_valid; then DRAIN->IDLE with done=1 coincident with the last rd_valid.
REQ-031 mem_read and mem_write SHALL never both be 1; both are 0 in IDLE and DRAIN.
REQ-032 wr_ready SHALL be 0 outside WRITE; wr_valid outside WRITE is ignored.
REQ-033 cmd_valid outside IDLE is ignored and not queued.

Reset
REQ-034 When rst_n=0 at a clock edge, the state SHALL become IDLE; done, rd_valid, mem_read, mem_write, and wr_ready are 0; the counters and mem_addr are 0; rd_data is 0; cmd_ready is 1 on the first cycle after release.
REQ-035 Reset mid-burst SHALL abort the burst: no further memory strobes, no pending rd_valid, no done.

Structure
REQ-036 Package mem_pkg SHALL hold ADDR_W/DATA_W/LEN_W defaults and the state enum type; it is shared with the memory and the bench.
REQ-037 The block is a single module with no sub-modules; the memory side SHALL connect through the existing mem_intf signals (clk, write, read, addr, data_in, data_out).

Verification
REQ-038 Write burst addr=4, len=3, wr_valid always 1, data A0..A3 -> 4 consecutive mem_write cycles at addr 4..7, done one cycle after the last.
REQ-039 Read burst addr=4, len=3 after REQ-038 -> mem_read at 4..7 on consecutive cycles, rd_valid with A0..A3 on cycles +2..+5, done with the last beat.
REQ-040 Write addr=30, len=3, data 11..14 -> addresses 30, 31, 0, 1; a read-back returns 11..14.
REQ-041 Write burst with wr_valid toggled 1,0,0,1,1 -> mem_write only in valid cycles, still exactly len+1 beats, cmd_ready 0 throughout.
REQ-042 rst_n=0 during beat 2 of an 8-beat read -> no mem_read, rd_valid, or done after the reset edge; a new command is accepted the first cycle after release.
REQ-043 Every cycle of all tests -> assert !(mem_read && mem_write), and the rd_valid count equals the beats issued.
